crossing_request_arbiter: RTL
=============================

// Module: crossing_request_arbiter
// PURPOSE
//  Collects pedestrian push-button requests from the three crossings (N, TH1, TH2),
//  debounces and latches them, and arbitrates one at a time to the general light FSM
//  over a req/ack/done handshake. Round-robin fairness with starvation escalation.
//  Sits between the board GPIO buttons and the general FSM, clocked by the 10 kHz LFOSC.
// PARAMETERS
//  N_REQ             3      number of requesters; index 0=N, 1=TH1, 2=TH2
//  DEBOUNCE_CYCLES   100    stable-level cycles needed to accept a button edge (10 ms)
//  TICKS_PER_S       10000  clk cycles per second tick
//  MAX_WAIT_S        60     seconds pending before requester becomes urgent
//  SERVICE_TIMEOUT_S 30     max seconds from ack to svc_done before forced abort
// PORTS
//  clk         in   1      system clock (10 kHz)
//  reset       in   1      asynchronous, active-high reset
//  enable      in   1      arbitration enable (same as general FSM enable)
//  btn_raw     in   N_REQ  raw asynchronous buttons, active-high
//  svc_req     out  1      service offer valid
//  svc_id      out  2      index of offered requester, stable while svc_req=1
//  svc_ack     in   1      FSM accepts the offer (single-cycle pulse)
//  svc_done    in   1      FSM finished the pedestrian phase (single-cycle pulse)
//  pending     out  N_REQ  latched, not-yet-accepted requests
//  urgent      out  N_REQ  pending for >= MAX_WAIT_S seconds
//  busy        out  1      high in OFFER or SERVE
//  timeout_err out  1      sticky: a service exceeded SERVICE_TIMEOUT_S
// BEHAVIOUR
//  Reset (async): all outputs 0; state=IDLE; all counters 0; last_grant=N_REQ-1 (first grant to 0).
//  Input path: 2-FF synchroniser per button, then per-input counter; debounced level changes
//   only after DEBOUNCE_CYCLES consecutive equal synced samples. Rising debounced edge sets
//   pending[i] next cycle. Presses while pending[i]=1 are ignored (no queueing beyond 1).
//  Timebase: free-running counter 0..TICKS_PER_S-1, 1-cycle tick at wrap.
//  Wait counters: per requester, +1 per tick while pending[i]=1 and i not in OFFER;
//   saturate at MAX_WAIT_S; cleared on acceptance; urgent[i] = (wait[i] >= MAX_WAIT_S).
//  FSM states: IDLE, OFFER, SERVE, CLEAR.
//   IDLE : enable=1 and pending!=0 -> pick winner, register svc_id, svc_req=1 next cycle -> OFFER.
//          Winner: if any urgent, round-robin over urgent set; else round-robin over pending,
//          search starts at last_grant+1 mod N_REQ.
//   OFFER: svc_req, svc_id held stable. svc_ack -> clear pending[id] and wait[id], svc_req=0
//          next cycle -> SERVE. enable=0 -> withdraw (svc_req=0, pending kept) -> IDLE.
//   SERVE: service second-counter runs. svc_done -> CLEAR. Counter reaches SERVICE_TIMEOUT_S
//          -> timeout_err=1 (sticky until reset) -> CLEAR. enable has no effect in SERVE.
//   CLEAR: one cycle; last_grant=svc_id; service counter=0 -> IDLE.
//  Min latency: pending set -> svc_req high = 2 cycles (IDLE evaluates, output registered).
//  Simultaneous: debounced edge for id on svc_ack cycle -> set wins, pending[id] stays 1.
//   svc_ack outside OFFER and svc_done outside SERVE are ignored.
//   svc_ack and enable falling in same OFFER cycle -> ack wins (go SERVE).
//  Reset mid-operation: immediate return to reset values, in-flight request discarded.
//  Widths: wait counters $clog2(MAX_WAIT_S+1); service counter $clog2(SERVICE_TIMEOUT_S+1).
// TESTING  (bench params: DEBOUNCE_CYCLES=4, TICKS_PER_S=10, MAX_WAIT_S=3, SERVICE_TIMEOUT_S=5)
//  1 btn_raw[1] high 3 cycles then low -> pending stays 000; high 8 cycles -> pending=010.
//  2 pending=010, enable=1 -> svc_req=1, svc_id=1; ack -> pending=000, svc_req=0; done -> busy=0.
//  3 all three pressed together -> grants in order 0,1,2; after re-press of 0 during SERVE of 2,
//    next grant is 0.
//  4 hold FSM busy serving 0 for 40 cycles with 1,2 pending -> urgent=110; next grant 1, then 2.
//  5 OFFER with no ack, drop enable -> svc_req=0 next cycle, pending unchanged, state IDLE.
//  6 ack then no done for 50 cycles -> timeout_err=1, busy=0; assert reset mid-SERVE -> all 0.

Source files
------------

// File: rtl/crossing_request_arbiter.sv
// Pedestrian push-button collector and one-at-a-time service arbiter.
// Debounce, latch, round-robin with urgent escalation, req/ack/done handshake.
module crossing_request_arbiter #(
  parameter int N_REQ             = 3,
  parameter int DEBOUNCE_CYCLES   = 100,
  parameter int TICKS_PER_S       = 10000,
  parameter int MAX_WAIT_S        = 60,
  parameter int SERVICE_TIMEOUT_S = 30,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] btn_raw,
  output logic             svc_req,
  output logic [IW-1:0]    svc_id,
  input  logic             svc_ack,
  input  logic             svc_done,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] urgent,
  output logic             busy,
  output logic             timeout_err
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
  localparam int WW = $clog2(MAX_WAIT_S + 1);
  localparam int SW = $clog2(SERVICE_TIMEOUT_S + 1);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    SERVE,
    CLEAR
  } state_t;

  state_t state;

  logic [N_REQ-1:0] sync1;
  logic [N_REQ-1:0] sync2;
  logic [N_REQ-1:0] db;
  logic [N_REQ-1:0] db_q;
  logic [N_REQ-1:0] rise;
  logic [DW-1:0]    db_cnt [N_REQ];

  logic [TW-1:0]    tb_cnt;
  logic             tick;

  logic [WW-1:0]    wait_cnt [N_REQ];
  logic [SW-1:0]    svc_cnt;

  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    idx;
  logic             found;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] urg_p;
  logic [N_REQ-1:0] offered;
  logic [N_REQ-1:0] accept;

  // two-flop synchroniser on the raw buttons
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // debounced level flips after a run of differing synced samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < N_REQ; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign rise = db & ~db_q;

  // free-running second timebase, tick on the wrap cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_cnt <= '0;
    end else if (tick) begin
      tb_cnt <= '0;
    end else begin
      tb_cnt <= tb_cnt + TW'(1);
    end
  end

  assign tick = (tb_cnt == TW'(TICKS_PER_S - 1));

  // which requester is on offer / being accepted this cycle
  always_comb begin
    offered = '0;
    accept  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      offered[i] = (state == OFFER) && (svc_id == IW'(i));
      accept[i]  = offered[i] && svc_ack;
    end
  end

  // request latch and per-requester wait-seconds counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (rise[i]) begin
          pending[i] <= 1'b1;
        end else if (accept[i]) begin
          pending[i] <= 1'b0;
        end
        if (accept[i]) begin
          wait_cnt[i] <= '0;
        end else if (tick && pending[i] && !offered[i] &&
                     wait_cnt[i] != WW'(MAX_WAIT_S)) begin
          wait_cnt[i] <= wait_cnt[i] + WW'(1);
        end
      end
    end
  end

  // starvation flag straight from the saturating wait counters
  always_comb begin
    urgent = '0;
    for (int i = 0; i < N_REQ; i++) begin
      urgent[i] = (wait_cnt[i] >= WW'(MAX_WAIT_S));
    end
  end

  // round-robin pick over the urgent set if any, else over pending
  always_comb begin
    urg_p  = urgent & pending;
    cand   = (|urg_p) ? urg_p : pending;
    winner = last_grant;
    found  = 1'b0;
    idx    = last_grant;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
      if (!found && cand[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // offer / serve handshake with service timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      svc_req     <= 1'b0;
      svc_id      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      svc_cnt     <= '0;
      last_grant  <= IW'(N_REQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && (|pending)) begin
            svc_id  <= winner;
            svc_req <= 1'b1;
            busy    <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (svc_ack) begin
            svc_req <= 1'b0;
            svc_cnt <= '0;
            state   <= SERVE;
          end else if (!enable) begin
            svc_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVE: begin
          if (svc_done) begin
            busy  <= 1'b0;
            state <= CLEAR;
          end else if (svc_cnt == SW'(SERVICE_TIMEOUT_S)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= CLEAR;
          end else if (tick) begin
            svc_cnt <= svc_cnt + SW'(1);
          end
        end
        CLEAR: begin
          last_grant <= svc_id;
          svc_cnt    <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
